// File: rtl/overflow_arbiter_pkg.sv
// overflow_arbiter_pkg: shared chess-clock constants, arbiter state encodings and index-width helper.
package overflow_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_ENDED = 2'b10;

    localparam int N_CH_MIN = 2;
    localparam int N_CH_MAX = 8;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ovf_prio_enc.sv
// ovf_prio_enc: lowest-index priority encoder with a more-than-one-set detector.
module ovf_prio_enc
    import overflow_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    localparam int IDXW = idx_w(N_CH)
) (
    input  logic [N_CH-1:0] q,
    output logic [IDXW-1:0] idx,
    output logic            multi
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (q[i]) idx = IDXW'(i);
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(q & (q - N_CH'(1)));

endmodule

// File: rtl/overflow_arbiter.sv
// overflow_arbiter: decides which player's clock overflowed first and latches the result
// until the game end is acknowledged.
module overflow_arbiter
    import overflow_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int EDGE_MODE = 1,
    localparam int IDXW = idx_w(N_CH)
) (
    input  logic            CLK,
    input  logic            CLR_N,
    input  logic            CE,
    input  logic            START,
    input  logic            ACK,
    input  logic [N_CH-1:0] OVERFLOW,
    input  logic [N_CH-1:0] MASK,
    output logic            END,
    output logic            TIE,
    output logic [IDXW-1:0] LOSER,
    output logic [N_CH-1:0] LOSER_VEC,
    output logic            ARMED
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("overflow_arbiter: N_CH out of range");
    end

    state_t          state;
    logic [N_CH-1:0] ovf_d;
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] q;
    logic [IDXW-1:0] idx;
    logic            multi;

    // Tracked every cycle so edges seen while idle or clock-disabled are consumed.
    always_ff @(posedge CLK or negedge CLR_N)
        if (!CLR_N) ovf_d <= '0;
        else        ovf_d <= OVERFLOW;

    assign ev = (EDGE_MODE != 0) ? (OVERFLOW & ~ovf_d) : OVERFLOW;
    assign q  = ev & ~MASK & {N_CH{CE}};

    ovf_prio_enc #(.N_CH(N_CH)) u_prio (
        .q     (q),
        .idx   (idx),
        .multi (multi)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state     <= ST_IDLE;
            END       <= 1'b0;
            TIE       <= 1'b0;
            ARMED     <= 1'b0;
            LOSER     <= '0;
            LOSER_VEC <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (START) begin
                        state <= ST_RUN;
                        ARMED <= 1'b1;
                    end
                ST_RUN:
                    if (|q) begin
                        state     <= ST_ENDED;
                        ARMED     <= 1'b0;
                        END       <= 1'b1;
                        TIE       <= multi;
                        LOSER     <= idx;
                        LOSER_VEC <= q;
                    end
                ST_ENDED:
                    if (ACK) begin
                        state     <= ST_IDLE;
                        END       <= 1'b0;
                        TIE       <= 1'b0;
                        LOSER     <= '0;
                        LOSER_VEC <= '0;
                    end
                default: begin
                    state     <= ST_IDLE;
                    END       <= 1'b0;
                    TIE       <= 1'b0;
                    ARMED     <= 1'b0;
                    LOSER     <= '0;
                    LOSER_VEC <= '0;
                end
            endcase
        end
    end

endmodule
